// File: rtl/sn76489_cmd_writer.sv
// Host-side command writer for an SN76489-compatible PSG: queues register-update
// commands and serialises them into paced latch/data byte writes.
module sn76489_cmd_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WRITE_GAP  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_enable,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_kind,
    input  logic [1:0] cmd_chan,
    input  logic [9:0] cmd_value,
    output logic       cmd_err,
    output logic [7:0] data,
    output logic       we,
    output logic       busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int GW = (WRITE_GAP > 0) ? $clog2(WRITE_GAP + 1) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LATCH   = 2'd1;
    localparam logic [1:0] ST_DATA    = 2'd2;

    localparam logic [1:0] KIND_TONE  = 2'b00;
    localparam logic [1:0] KIND_ATTN  = 2'b01;
    localparam logic [1:0] KIND_NOISE = 2'b10;

    localparam logic [GW-1:0] GAP_LOAD  = GW'(WRITE_GAP);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    // First byte of any command: the latch byte carrying the register address.
    function automatic logic [7:0] latch_byte(input logic [1:0] kind,
                                              input logic [1:0] chan,
                                              input logic [9:0] value);
        logic [7:0] b;
        case (kind)
            KIND_TONE:  b = {1'b1, chan, 1'b0, value[3:0]};
            KIND_ATTN:  b = {1'b1, chan, 1'b1, value[3:0]};
            KIND_NOISE: b = {1'b1, 2'b11, 1'b0, 1'b0, value[2:0]};
            default:    b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] data_byte(input logic [9:0] value);
        return {2'b00, value[9:4]};
    endfunction

    logic [13:0]   fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [1:0]    work_kind_r;
    logic [1:0]    work_chan_r;
    logic [9:0]    work_value_r;
    logic [9:0]    shadow_r [4];
    logic [GW-1:0] gap_r;
    logic          cmd_err_r;

    logic fifo_full_s;
    logic fifo_empty_s;
    logic accept_s;
    logic invalid_s;
    logic push_s;
    logic pop_s;
    logic fire_s;
    logic need_data_s;
    logic [7:0] data_s;

    assign fifo_full_s  = (count_r == FIFO_FULL);
    assign fifo_empty_s = (count_r == {CW{1'b0}});
    assign invalid_s    = (cmd_kind == 2'b11) || ((cmd_kind == KIND_TONE) && (cmd_chan == 2'd3));
    assign accept_s     = cmd_valid && !fifo_full_s;
    assign push_s       = accept_s && !invalid_s;
    assign pop_s        = (state_r == ST_IDLE) && !fifo_empty_s;
    assign fire_s       = (state_r != ST_IDLE) && clk_enable && (gap_r == {GW{1'b0}});
    assign need_data_s  = (work_kind_r == KIND_TONE) &&
                          (work_value_r[9:4] != shadow_r[work_chan_r][9:4]);

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {cmd_kind, cmd_chan, cmd_value};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Next-state logic for the byte serialiser.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = ST_LATCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LATCH: begin
                if (fire_s) begin
                    state_nxt_s = need_data_s ? ST_DATA : ST_IDLE;
                end else begin
                    state_nxt_s = ST_LATCH;
                end
            end
            ST_DATA: begin
                if (fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, working command and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            work_kind_r  <= 2'b00;
            work_chan_r  <= 2'b00;
            work_value_r <= 10'h000;
            cmd_err_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cmd_err_r <= accept_s && invalid_s;
            if (pop_s) begin
                {work_kind_r, work_chan_r, work_value_r} <= fifo_mem_r[rd_ptr_r];
            end
        end
    end

    // Tone-period shadows mirror what the PSG holds, low nibble then high bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                shadow_r[i] <= 10'h001;
            end
        end else if (fire_s && (work_kind_r == KIND_TONE)) begin
            if (state_r == ST_LATCH) begin
                shadow_r[work_chan_r][3:0] <= work_value_r[3:0];
            end else begin
                shadow_r[work_chan_r][9:4] <= work_value_r[9:4];
            end
        end
    end

    // Inter-write gap: reloaded on each write, counts only on enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_r <= {GW{1'b0}};
        end else if (fire_s) begin
            gap_r <= GAP_LOAD;
        end else if (clk_enable && (gap_r != {GW{1'b0}})) begin
            gap_r <= gap_r - GW'(1);
        end else begin
            gap_r <= gap_r;
        end
    end

    // Byte presented on the PSG bus for the current serialiser state.
    always_comb begin
        data_s = 8'h00;
        case (state_r)
            ST_LATCH: data_s = latch_byte(work_kind_r, work_chan_r, work_value_r);
            ST_DATA:  data_s = data_byte(work_value_r);
            default:  data_s = 8'h00;
        endcase
    end

    assign data      = data_s;
    assign we        = fire_s;
    assign cmd_ready = !fifo_full_s;
    assign cmd_err   = cmd_err_r;
    assign busy      = !fifo_empty_s || (state_r != ST_IDLE);

endmodule
